// File: rtl/mdio_pkg.sv
// mdio_pkg: shared frame-field positions, opcodes, FSM states and the frame decoder
// for the Clause 22/45 MDIO slave backend.
package mdio_pkg;

   localparam logic [1:0] ST_C22 = 2'b01;
   localparam logic [1:0] ST_C45 = 2'b00;

   localparam logic [1:0] C22_OP_WR = 2'b01;
   localparam logic [1:0] C22_OP_RD = 2'b10;

   localparam logic [1:0] C45_OP_ADDR = 2'b00;
   localparam logic [1:0] C45_OP_WR   = 2'b01;
   localparam logic [1:0] C45_OP_PRI  = 2'b10;
   localparam logic [1:0] C45_OP_RD   = 2'b11;

   localparam int ST_LSB    = 30;
   localparam int OP_LSB    = 28;
   localparam int REGAD_LSB = 18;
   localparam int DATA_LSB  = 0;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      RD_WAIT = 4'b0010,
      RD_HOLD = 4'b0100,
      WR_WAIT = 4'b1000
   } state_e;

   typedef enum logic [2:0] {K_NONE, K_ADDR, K_WR, K_RD, K_PRI} kind_e;

   function automatic kind_e decode(input logic [31:0] w);
      logic [1:0] st;
      logic [1:0] op;
      st = w[ST_LSB +: 2];
      op = w[OP_LSB +: 2];
      if (st == ST_C22)
         return (op == C22_OP_WR) ? K_WR : (op == C22_OP_RD) ? K_RD : K_NONE;
      if (st == ST_C45)
         return (op == C45_OP_ADDR) ? K_ADDR : (op == C45_OP_WR) ? K_WR :
                (op == C45_OP_RD) ? K_RD : (op == C45_OP_PRI) ? K_PRI : K_NONE;
      return K_NONE;
   endfunction

endpackage

// File: rtl/mdio_slave_22_45_backend_if.sv
// mdio_slave_22_45_backend_if: frontend request/response and register-bus signals.
// slave = the backend's view; master = the frontend plus register-bus side.
interface mdio_slave_22_45_backend_if;
   logic        legal;
   logic [31:0] req_data;
   logic        req_phyaddr_done;
   logic        req_regaddr_done;
   logic        req_frame_done;
   logic [15:0] resp_rdata;
   logic        resp_ready;
   logic        reg_rd;
   logic        reg_wr;
   logic        reg_c45;
   logic [4:0]  reg_devad;
   logic [15:0] reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;
   logic        reg_rdy;
   logic        err_timeout;

   modport slave (
      input  legal, req_data, req_phyaddr_done, req_regaddr_done, req_frame_done,
             reg_rdata, reg_rdy,
      output resp_rdata, resp_ready, reg_rd, reg_wr, reg_c45, reg_devad, reg_addr,
             reg_wdata, err_timeout
   );

   modport master (
      output legal, req_data, req_phyaddr_done, req_regaddr_done, req_frame_done,
             reg_rdata, reg_rdy,
      input  resp_rdata, resp_ready, reg_rd, reg_wr, reg_c45, reg_devad, reg_addr,
             reg_wdata, err_timeout
   );
endinterface

// File: rtl/mdio_slave_22_45_backend.sv
// mdio_slave_22_45_backend: decodes C22/C45 frames from the MDIO frontend, drives the
// req/rdy register bus, returns read data and keeps the C45 address register.
module mdio_slave_22_45_backend
   import mdio_pkg::*;
#(
   parameter int RD_TIMEOUT = 12,
   parameter int WR_TIMEOUT = 32
) (
   input logic                         clk_25m,
   input logic                         rst_n,
   mdio_slave_22_45_backend_if.slave   bus
);

   localparam int CNT_W = 8;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        addr45_q, addr45_d;
   logic               pri_q, pri_d;
   logic [15:0]        resp_rdata_q, resp_rdata_d;
   logic               resp_ready_q, resp_ready_d;
   logic               reg_rd_q, reg_rd_d;
   logic               reg_wr_q, reg_wr_d;
   logic               c45_q, c45_d;
   logic [4:0]         devad_q, devad_d;
   logic [15:0]        addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               err_q, err_d;

   kind_e       kind;
   logic        is_c45, fd, ra, idle, rd_to, wr_to;
   logic        launch_rd, launch_wr, set_addr, hold_done, abort, rd_done, wr_done;
   logic [4:0]  field5;
   logic        unused_ok;

   assign unused_ok = ^{bus.req_phyaddr_done, bus.req_data[27:23], bus.req_data[17:16]};

   // frame_done wins a coincidence with regaddr_done; the latter is then dropped
   assign kind      = decode(bus.req_data);
   assign is_c45    = bus.req_data[ST_LSB +: 2] == ST_C45;
   assign field5    = bus.req_data[REGAD_LSB +: 5];
   assign fd        = bus.legal & bus.req_frame_done;
   assign ra        = bus.legal & bus.req_regaddr_done & ~fd;
   assign idle      = state_q == IDLE;
   assign rd_to     = cnt_q >= CNT_W'(RD_TIMEOUT - 1);
   assign wr_to     = cnt_q >= CNT_W'(WR_TIMEOUT - 1);
   assign launch_rd = idle & ra & (kind == K_RD || kind == K_PRI);
   assign launch_wr = idle & fd & (kind == K_WR);
   assign set_addr  = idle & fd & (kind == K_ADDR);
   assign hold_done = (state_q == RD_HOLD) & fd;
   assign abort     = ~idle & (ra | fd) & ~hold_done;
   assign rd_done   = (state_q == RD_WAIT) & ~abort & (bus.reg_rdy | rd_to);
   assign wr_done   = (state_q == WR_WAIT) & ~abort & (bus.reg_rdy | wr_to);

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = abort     ? IDLE    :
                launch_rd ? RD_WAIT :
                launch_wr ? WR_WAIT :
                rd_done   ? RD_HOLD :
                wr_done   ? IDLE    :
                hold_done ? IDLE    : state_q;
   end

   always_comb begin
      cnt_d        = (state_d == state_q && (state_q == RD_WAIT || state_q == WR_WAIT)) ?
                     cnt_q + 1'b1 : '0;
      c45_d        = (launch_rd | launch_wr) ? is_c45 : c45_q;
      devad_d      = (launch_rd | launch_wr) ? (is_c45 ? field5 : 5'd0) : devad_q;
      addr_d       = (launch_rd | launch_wr) ? (is_c45 ? addr45_q : {11'b0, field5}) : addr_q;
      wdata_d      = launch_wr ? bus.req_data[DATA_LSB +: 16] : wdata_q;
      pri_d        = launch_rd ? (kind == K_PRI) : pri_q;
      reg_rd_d     = state_d == RD_WAIT;
      reg_wr_d     = state_d == WR_WAIT;
      resp_rdata_d = rd_done ? (bus.reg_rdy ? bus.reg_rdata : 16'hFFFF) : resp_rdata_q;
      resp_ready_d = rd_done ? 1'b1 : (launch_rd | hold_done | abort) ? 1'b0 : resp_ready_q;
      err_d        = err_q | abort | ((rd_done | wr_done) & ~bus.reg_rdy);
      addr45_d     = set_addr ? bus.req_data[DATA_LSB +: 16] :
                     (hold_done & pri_q) ? addr45_q + 16'd1 : addr45_q;
   end

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         addr45_q     <= '0;
         pri_q        <= 1'b0;
         resp_rdata_q <= '0;
         resp_ready_q <= 1'b0;
         reg_rd_q     <= 1'b0;
         reg_wr_q     <= 1'b0;
         c45_q        <= 1'b0;
         devad_q      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         addr45_q     <= addr45_d;
         pri_q        <= pri_d;
         resp_rdata_q <= resp_rdata_d;
         resp_ready_q <= resp_ready_d;
         reg_rd_q     <= reg_rd_d;
         reg_wr_q     <= reg_wr_d;
         c45_q        <= c45_d;
         devad_q      <= devad_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
      end
   end

   assign bus.resp_rdata  = resp_rdata_q;
   assign bus.resp_ready  = resp_ready_q;
   assign bus.reg_rd      = reg_rd_q;
   assign bus.reg_wr      = reg_wr_q;
   assign bus.reg_c45     = c45_q;
   assign bus.reg_devad   = devad_q;
   assign bus.reg_addr    = addr_q;
   assign bus.reg_wdata   = wdata_q;
   assign bus.err_timeout = err_q;

endmodule
